// File: rtl/psum_deskew_drain_pkg.sv
// Shared widths and row-entry layout for the systolic-array drain stage.
// The defaults describe the reference configuration (19-bit operands, 6 columns, 4-deep FIFO).
package psum_deskew_drain_pkg;
    localparam int DEF_DATA_WIDTH = 19;
    localparam int DEF_COLS       = 6;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int SUM_W          = 2 * DEF_DATA_WIDTH;
    localparam int ROW_W          = SUM_W * DEF_COLS;
    localparam int ENTRY_W        = ROW_W + 1;
    localparam int TILE_W         = 16;

    typedef struct packed {
        logic             last;
        logic [ROW_W-1:0] data;
    } row_entry_t;

    // A tile length of zero behaves as a single-row tile.
    function automatic logic [TILE_W-1:0] tile_len(input logic [TILE_W-1:0] rows);
        return (rows == '0) ? TILE_W'(1) : rows;
    endfunction
endpackage

// File: rtl/psum_row_fifo.sv
// Row buffer: synchronous FIFO, entry visible at the head the cycle after it is written.
// Latency 1 cycle push-to-head; push is taken when not full or when a pop happens on the same edge.
// Backpressure: caller sees full; head holds steady until popped.
module psum_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Gate the head so stale entries never leak out while empty.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/psum_deskew_drain.sv
// Deskews the last PE row's column sums into one aligned word per output row, tags tile ends.
// Latency: out_valid rises the cycle after the edge that captures the last column (COLS cycles after in_valid).
// Backpressure: out_valid/out_ready; completed rows are dropped (sticky overflow) when the FIFO is full.
module psum_deskew_drain
    import psum_deskew_drain_pkg::*;
#(
    parameter int data_width         = DEF_DATA_WIDTH,
    parameter int w_tile_column_size = DEF_COLS,
    parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        clear,
    input  logic [TILE_W-1:0]                           tile_rows,
    input  logic                                        in_valid,
    input  logic [2*data_width*w_tile_column_size-1:0]  in_sum,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [2*data_width*w_tile_column_size-1:0]  out_data,
    output logic                                        out_last,
    output logic                                        overflow,
    output logic                                        busy
);
    localparam int SW = 2 * data_width;
    localparam int NC = w_tile_column_size;
    localparam int RW = SW * NC;

    typedef struct packed {
        logic          last;
        logic [RW-1:0] data;
    } entry_t;

    logic [NC-1:0]     vtag;
    logic [SW-1:0]     lane_out [NC];
    logic [RW-1:0]     row_dat;
    logic              row_done;
    logic              pop;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [TILE_W-1:0] row_cnt;
    logic [TILE_W-1:0] tile_len_q;
    logic [TILE_W-1:0] len_eff;
    logic              row_last;
    entry_t            push_entry;
    entry_t            head_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vtag <= '0;
        else if (clear) vtag <= '0;
        else            vtag <= {vtag[NC-2:0], in_valid};
    end

    // Lane j is captured on its own valid edge, then ages so every lane lands on the push edge.
    for (genvar j = 0; j < NC - 1; j++) begin : g_lane
        localparam int D = NC - 1 - j;
        logic          cap;
        logic [SW-1:0] pipe [D];

        if (j == 0) begin : g_cap0
            assign cap = in_valid;
        end else begin : g_capn
            assign cap = vtag[j-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < D; k++) pipe[k] <= '0;
            end else begin
                if (cap) pipe[0] <= in_sum[j*SW +: SW];
                for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
            end
        end

        assign lane_out[j] = pipe[D-1];
    end
    assign lane_out[NC-1] = in_sum[(NC-1)*SW +: SW];

    always_comb begin
        row_dat = '0;
        for (int j = 0; j < NC; j++) row_dat[j*SW +: SW] = lane_out[j];
    end

    assign row_done = vtag[NC-2] && !clear;
    assign pop      = out_valid && out_ready;
    assign push_ok  = row_done && (!fifo_full || pop);

    // Tile length is sampled only at the first row of a tile.
    always_comb begin
        len_eff  = (row_cnt == '0) ? tile_len(tile_rows) : tile_len_q;
        row_last = (row_cnt == len_eff - TILE_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt    <= '0;
            tile_len_q <= TILE_W'(1);
            overflow   <= 1'b0;
        end else if (clear) begin
            row_cnt    <= '0;
            tile_len_q <= TILE_W'(1);
            overflow   <= 1'b0;
        end else begin
            if (row_done) begin
                tile_len_q <= len_eff;
                row_cnt    <= row_last ? '0 : row_cnt + TILE_W'(1);
            end
            if (row_done && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    assign push_entry.last = row_last;
    assign push_entry.data = row_dat;

    psum_row_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .push     (push_ok),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_entry.data;
    assign out_last  = head_entry.last;
    assign busy      = (|vtag) || !fifo_empty;
endmodule

// File: tb/tb_psum_deskew_drain.sv
// Self-checking bench for psum_deskew_drain: per-cycle scoreboard against a row-level model,
// a table of directed scenarios, and hand sequences for latency, full+pop+push and clear/reset mid-row.
`timescale 1ns/1ps
module tb_psum_deskew_drain;
    localparam int DW  = 19;
    localparam int NC  = 6;
    localparam int DEP = 4;
    localparam int SW  = 2 * DW;
    localparam int RW  = SW * NC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [15:0]   tile_rows;
    logic          in_valid;
    logic [RW-1:0] in_sum;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    psum_deskew_drain #(
        .data_width         (DW),
        .w_tile_column_size (NC),
        .FIFO_DEPTH         (DEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .tile_rows (tile_rows),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [RW-1:0] data;
        logic          last;
    } mrow_t;

    // Reference model: history of sampled inputs, queue of buffered rows, tile position.
    mrow_t         mq[$];
    bit            vhist [NC];
    logic [RW-1:0] shist [NC];
    int            m_cnt;
    int            m_len;
    bit            m_ovf;
    int            beats;
    int            lasts;

    task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < NC; k++) begin
            vhist[k] = 1'b0;
            shist[k] = '0;
        end
        m_cnt = 0;
        m_len = 1;
        m_ovf = 1'b0;
    endtask

    // Called with the inputs that the coming rising edge will sample.
    task automatic model_edge();
        bit    pop;
        mrow_t r;
        if (!rst_n || clear) begin
            model_reset();
            return;
        end
        if (out_valid && out_ready) begin
            beats++;
            if (out_last) lasts++;
        end
        pop = (mq.size() > 0) && out_ready;
        for (int k = NC - 1; k > 0; k--) begin
            vhist[k] = vhist[k-1];
            shist[k] = shist[k-1];
        end
        vhist[0] = in_valid;
        shist[0] = in_sum;
        if (pop) void'(mq.pop_front());
        if (vhist[NC-1]) begin
            // Lane j of a row started at edge E0 is the lane-j value sampled at edge E0+j.
            r.data = '0;
            for (int j = 0; j < NC; j++) r.data[j*SW +: SW] = shist[NC-1-j][j*SW +: SW];
            if (m_cnt == 0) m_len = (tile_rows == 0) ? 1 : int'(tile_rows);
            r.last = (m_cnt == m_len - 1);
            m_cnt  = r.last ? 0 : m_cnt + 1;
            if (mq.size() < DEP) mq.push_back(r);
            else                 m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        bit any = 1'b0;
        for (int k = 0; k < NC; k++) any |= vhist[k];
        chk("out_valid", RW'(out_valid), RW'(mq.size() > 0));
        chk("out_data", out_data, (mq.size() > 0) ? mq[0].data : '0);
        chk("out_last", RW'(out_last), RW'((mq.size() > 0) ? mq[0].last : 1'b0));
        chk("overflow", RW'(overflow), RW'(m_ovf));
        chk("busy", RW'(busy), RW'(any || (mq.size() > 0)));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_sum();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        in_sum = t[RW-1:0];
    endtask

    task automatic drive(input bit v);
        rand_sum();
        in_valid = v;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    task automatic send_rows(input int n, input int gap);
        for (int r = 0; r < n; r++) begin
            drive(1'b1);
            idle(gap);
        end
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    typedef struct {
        logic [15:0] tile;
        int          rows;
        int          gap;
        bit          ready;
        int          exp_beats;
        int          exp_lasts;
        bit          exp_ovf;
    } scen_t;

    scen_t         tbl [5];
    logic [RW-1:0] exp_row;

    initial begin
        tbl[0] = '{16'd4, 4, 0, 1'b1, 4, 1, 1'b0};
        tbl[1] = '{16'd4, 5, 0, 1'b0, 4, 1, 1'b1};
        tbl[2] = '{16'd0, 3, 2, 1'b1, 3, 3, 1'b0};
        tbl[3] = '{16'd2, 5, 1, 1'b1, 5, 2, 1'b0};
        tbl[4] = '{16'd3, 6, 0, 1'b0, 4, 1, 1'b1};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tile_rows = 16'd4;
        in_sum    = '0;
        beats     = 0;
        lasts     = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // Idle after reset: random sums without valid must produce nothing.
        idle(6);
        chk("idle_busy", RW'(busy), '0);
        chk("idle_data", out_data, '0);

        // Single row, lane j = j+1 on its own edge; appears after the sixth edge.
        do_clear();
        tile_rows = 16'd4;
        out_ready = 1'b0;
        for (int k = 0; k < NC; k++) begin
            rand_sum();
            in_sum[k*SW +: SW] = SW'(k + 1);
            in_valid = (k == 0);
            tick();
            chk("lat_valid", RW'(out_valid), RW'(k == NC - 1));
        end
        exp_row = '0;
        for (int j = 0; j < NC; j++) exp_row[j*SW +: SW] = SW'(j + 1);
        chk("lat_data", out_data, exp_row);
        chk("lat_last", RW'(out_last), '0);
        out_ready = 1'b1;
        idle(3);

        for (int s = 0; s < 5; s++) begin
            do_clear();
            tile_rows = tbl[s].tile;
            out_ready = tbl[s].ready;
            beats = 0;
            lasts = 0;
            send_rows(tbl[s].rows, tbl[s].gap);
            idle(8);
            out_ready = 1'b1;
            idle(8);
            chk("tbl_beats", RW'(beats), RW'(tbl[s].exp_beats));
            chk("tbl_lasts", RW'(lasts), RW'(tbl[s].exp_lasts));
            chk("tbl_ovf", RW'(overflow), RW'(tbl[s].exp_ovf));
        end

        // Full FIFO with a pop on the same edge as the fifth push: nothing is dropped.
        do_clear();
        tile_rows = 16'd4;
        out_ready = 1'b0;
        beats = 0;
        send_rows(5, 0);
        idle(4);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("fpp_ovf", RW'(overflow), '0);
        chk("fpp_beats1", RW'(beats), RW'(1));
        idle(2);
        out_ready = 1'b1;
        idle(8);
        chk("fpp_beats", RW'(beats), RW'(5));
        chk("fpp_ovf_end", RW'(overflow), '0);

        // Clear and reset three edges into a row: row vanishes, tile position restarts.
        for (int mode = 0; mode < 2; mode++) begin
            do_clear();
            tile_rows = 16'd2;
            out_ready = 1'b1;
            send_rows(1, 0);
            idle(8);
            drive(1'b1);
            idle(2);
            rand_sum();
            in_valid = 1'b0;
            if (mode == 0) clear = 1'b1;
            else           rst_n = 1'b0;
            tick();
            clear = 1'b0;
            rst_n = 1'b1;
            chk("abort_busy", RW'(busy), '0);
            chk("abort_valid", RW'(out_valid), '0);
            beats = 0;
            lasts = 0;
            idle(8);
            chk("abort_no_emit", RW'(beats), '0);
            send_rows(1, 0);
            idle(8);
            chk("abort_beats", RW'(beats), RW'(1));
            chk("abort_cnt_restart", RW'(lasts), '0);
        end

        // Randomized traffic against the model.
        do_clear();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) tile_rows = 16'($urandom_range(0, 5));
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 2) != 0);
            clear = 1'b0;
        end
        out_ready = 1'b1;
        idle(12);
        chk("final_busy", RW'(busy), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
